alu_ctl_seq: RTL and testbench
==============================

ALU_CTL_SEQ -- requirements
Module: alu_ctl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO data width (even, >= 8).
REQ-002 SHALL have parameter CTL_W, default 4, aluctl code width.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port valid  input  1  instruction in EX stage is real (not bubble).
REQ-006 SHALL have port funct  input  6  R-type funct field.
REQ-007 SHALL have port aluop  input  2  main-control ALU operation class.
REQ-008 SHALL have port rs_val  input  WIDTH  first operand (dividend/multiplicand, MTHI/MTLO source).
REQ-009 SHALL have port rt_val  input  WIDTH  second operand (divisor/multiplier).
REQ-010 SHALL have port aluctl  output  CTL_W  ALU operation code, combinational.
REQ-011 SHALL have port stall  output  1  hold EX and upstream this cycle, combinational.
REQ-012 SHALL have port hilo_out  output  WIDTH  MFHI/MFLO read data, combinational.
REQ-013 SHALL have port busy  output  1  mul/div sequencer not IDLE, registered.

Function
REQ-014 aluctl SHALL be: aluop 0 -> 2, 1 -> 6, 3 -> 2, 2 -> funct decode.
REQ-015 funct decode SHALL use all 6 bits: 0x20/0x21 -> 2, 0x22/0x23 -> 6, 0x24 -> 0, 0x25 -> 1, 0x26 -> 13, 0x27 -> 12, 0x2A -> 7, 0x2B -> 8, 0x00 -> 3, 0x02 -> 4, 0x03 -> 5, others -> 0.
REQ-016 HI/LO class (aluop 2): MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
REQ-017 FSM states SHALL be IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-018 IDLE + valid + mul/div funct SHALL latch operand magnitudes, signedness, result signs, load iteration counter = WIDTH, enter MUL or DIV next cycle; stall stays 0 (non-blocking issue).
REQ-019 MUL/DIV SHALL perform one radix-2 shift-add / restoring-subtract step per cycle; counter decrements; at counter 1 -> FIX.
REQ-020 FIX SHALL apply two's-complement sign correction (signed ops) and write HI/LO in one cycle, then -> IDLE; results visible WIDTH+2 cycles after issue edge.
REQ-021 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product.
REQ-022 DIV/DIVU: LO = quotient, HI = remainder; remainder sign follows dividend.
REQ-023 Divide by zero SHALL give LO = all ones, HI = rs_val (dividend), same latency, no exception.
REQ-024 stall SHALL be 1 iff valid && aluop==2 && funct in HI/LO class && busy.
REQ-025 Non-HI/LO instructions SHALL never stall, regardless of busy.
REQ-026 MTHI/MTLO in IDLE SHALL write rs_val to HI/LO at the clock edge; MFHI/MFLO SHALL drive hilo_out from current HI/LO, else hilo_out = 0.
REQ-027 HI/LO SHALL hold value except on FIX or MTHI/MTLO write.
REQ-028 valid = 0 SHALL suppress issue, HI/LO writes and stall; aluctl still decodes.

Reset
REQ-029 rst_n low at clock edge SHALL force state IDLE, HI = LO = 0, counter = 0, busy = 0, at any time incl. mid-operation; in-flight result discarded.
REQ-030 aluctl, stall, hilo_out SHALL follow their combinational rules during reset with busy = 0.

Structure
REQ-031 Shared package SHALL hold aluctl code constants, funct constants, FSM state enum.
REQ-032 Datapath SHALL be one sub-module muldiv_iter (operand regs, accumulator, counter); decode and stall logic stay in top.

Verification
REQ-033 aluop=2, funct=0x2B -> aluctl=8; aluop=1, any funct -> aluctl=6; funct=0x3F -> 0.
REQ-034 MULT rs=0xFFFFFFFF, rt=0x00000003 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFD; busy high 33 cycles.
REQ-035 DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7, rt=0 -> LO=0xFFFFFFFF, HI=7.
REQ-036 MFLO issued 1 cycle after MULTU -> stall=1 until cycle after FIX, then hilo_out=LO; ADD during busy -> stall=0.
REQ-037 rst_n low mid-DIV (cycle 10) -> next cycle busy=0, HI=LO=0; new MULTU 2*3 -> LO=6.
REQ-038 Sweep WIDTH=8 and 16: random signed/unsigned mul/div vs reference model, 1000 ops each.

Source files
------------

// File: rtl/alu_ctl_seq_pkg.sv
// Shared constants for the EX-stage ALU control decoder and HI/LO mul/div sequencer:
// aluop classes, aluctl codes, R-type funct values and the sequencer state enum.
package alu_ctl_seq_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE = 2'd2;
  localparam logic [1:0] ALUOP_IMM   = 2'd3;

  localparam logic [3:0] CTL_AND  = 4'd0;
  localparam logic [3:0] CTL_OR   = 4'd1;
  localparam logic [3:0] CTL_ADD  = 4'd2;
  localparam logic [3:0] CTL_SLL  = 4'd3;
  localparam logic [3:0] CTL_SRL  = 4'd4;
  localparam logic [3:0] CTL_SRA  = 4'd5;
  localparam logic [3:0] CTL_SUB  = 4'd6;
  localparam logic [3:0] CTL_SLT  = 4'd7;
  localparam logic [3:0] CTL_SLTU = 4'd8;
  localparam logic [3:0] CTL_NOR  = 4'd12;
  localparam logic [3:0] CTL_XOR  = 4'd13;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/alu_ctl_seq_muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, one step per
// cycle, followed by a single sign-fix cycle that presents the HI/LO result.
module muldiv_iter
  import alu_ctl_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     opnd_b, acc_hi, acc_lo;
  logic                 is_div, neg_quo, neg_rem, div_zero;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   prod, prod_fix;

  always_comb begin
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_b : {WIDTH{1'b0}})};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    q_bit     = ~div_diff[WIDTH];
  end

  // NOTE: every signal assigned in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = op_div ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (cnt == CNT_W'(1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      if (state == ST_IDLE && start) cnt <= CNT_W'(WIDTH);
      else if (state == ST_MUL || state == ST_DIV) cnt <= cnt - CNT_W'(1);
    end
  end

  // NOTE: operand/accumulator registers carry no reset; they are always loaded at issue before being read.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: if (start) begin
        opnd_b   <= b_mag;
        acc_hi   <= '0;
        acc_lo   <= a_mag;
        is_div   <= op_div;
        neg_quo  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= (b == '0);
      end
      ST_MUL: begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
      ST_DIV: begin
        acc_hi <= q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
      end
      default: ;
    endcase
  end

  // Remainder sign follows the dividend, which also makes HI return rs_val on divide by zero.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_quo ? -prod : prod;
    done     = (state == ST_FIX);
    if (is_div) begin
      res_lo = div_zero ? {WIDTH{1'b1}} : (neg_quo ? -acc_lo : acc_lo);
      res_hi = neg_rem ? -acc_hi : acc_hi;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_ctl_seq.sv
// EX-stage ALU control decode, HI/LO register file and stall generation around the
// iterative mul/div sequencer.
module alu_ctl_seq
  import alu_ctl_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [1:0]       aluop,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [CTL_W-1:0] aluctl,
  output logic             stall,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy
);

  logic [3:0]       ctl_code;
  logic             hilo_cls, issue, start, done;
  logic [WIDTH-1:0] hi, lo, res_hi, res_lo;

  always_comb begin
    ctl_code = CTL_AND;
    case (aluop)
      ALUOP_ADD, ALUOP_IMM: ctl_code = CTL_ADD;
      ALUOP_SUB:            ctl_code = CTL_SUB;
      default: begin
        case (funct)
          F_ADD, F_ADDU: ctl_code = CTL_ADD;
          F_SUB, F_SUBU: ctl_code = CTL_SUB;
          F_AND:         ctl_code = CTL_AND;
          F_OR:          ctl_code = CTL_OR;
          F_XOR:         ctl_code = CTL_XOR;
          F_NOR:         ctl_code = CTL_NOR;
          F_SLT:         ctl_code = CTL_SLT;
          F_SLTU:        ctl_code = CTL_SLTU;
          F_SLL:         ctl_code = CTL_SLL;
          F_SRL:         ctl_code = CTL_SRL;
          F_SRA:         ctl_code = CTL_SRA;
          default:       ctl_code = CTL_AND;
        endcase
      end
    endcase
  end

  assign aluctl = CTL_W'(ctl_code);

  // Only HI/LO-class instructions contend for the sequencer; everything else flows.
  assign hilo_cls = (aluop == ALUOP_RTYPE) && is_hilo_funct(funct);
  assign issue    = valid && hilo_cls && !busy;
  assign stall    = valid && hilo_cls && busy;
  assign start    = issue && is_muldiv_funct(funct);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_div    (funct[1]),
    .op_signed (~funct[0]),
    .a         (rs_val),
    .b         (rt_val),
    .busy      (busy),
    .done      (done),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (issue && funct == F_MTHI) begin
      hi <= rs_val;
    end else if (issue && funct == F_MTLO) begin
      lo <= rs_val;
    end
  end

  always_comb begin
    hilo_out = '0;
    if (aluop == ALUOP_RTYPE && funct == F_MFHI) hilo_out = hi;
    else if (aluop == ALUOP_RTYPE && funct == F_MFLO) hilo_out = lo;
  end

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Self-checking bench: three DUTs (WIDTH 32/16/8) against a cycle-level behavioural
// model of the HI/LO unit, with directed literal cases and random mul/div traffic.
module tb_alu_ctl_seq;

  localparam int NI = 3;
  localparam int WS [NI] = '{32, 16, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [NI-1:0]           valid, stall_o, busy_o;
  logic [NI-1:0][5:0]      funct;
  logic [NI-1:0][1:0]      aluop;
  logic [NI-1:0][31:0]     rs, rt, hilo_o;
  logic [NI-1:0][3:0]      aluctl_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int          m_left [NI];
  logic [31:0] m_hi [NI], m_lo [NI], m_phi [NI], m_plo [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 32 : ((g == 1) ? 16 : 8);
    logic [W-1:0] hilo_w;
    alu_ctl_seq #(.WIDTH(W), .CTL_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (valid[g]),
      .funct    (funct[g]),
      .aluop    (aluop[g]),
      .rs_val   (rs[g][W-1:0]),
      .rt_val   (rt[g][W-1:0]),
      .aluctl   (aluctl_o[g]),
      .stall    (stall_o[g]),
      .hilo_out (hilo_w),
      .busy     (busy_o[g])
    );
    assign hilo_o[g] = 32'(hilo_w);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic bit hilo_class(input logic [5:0] f);
    return f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
  endfunction

  function automatic logic [3:0] ctl_ref(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd1) return 4'd6;
    if (op != 2'd2) return 4'd2;
    case (f)
      6'h20, 6'h21: return 4'd2;
      6'h22, 6'h23: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h26: return 4'd13;
      6'h27: return 4'd12;
      6'h2A: return 4'd7;
      6'h2B: return 4'd8;
      6'h00: return 4'd3;
      6'h02: return 4'd4;
      6'h03: return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  // Reference arithmetic on plain integers, truncated to the instance width.
  function automatic void md_ref(input int w, input logic [5:0] f, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
    logic [31:0] m;
    logic [63:0] ua, ub, p;
    longint      sa, sb;
    m  = mask_of(w);
    ua = 64'(a & m);
    ub = 64'(b & m);
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    if (!f[1]) begin
      p  = f[0] ? (ua * ub) : 64'(sa * sb);
      lo = p[31:0] & m;
      hi = 32'(p >> w) & m;
    end else if (ub == 0) begin
      lo = m;
      hi = a & m;
    end else if (!f[0]) begin
      lo = 32'(sa / sb) & m;
      hi = 32'(sa % sb) & m;
    end else begin
      lo = 32'(ua / ub) & m;
      hi = 32'(ua % ub) & m;
    end
  endfunction

  // Behavioural model: a busy countdown of WIDTH+1 cycles, result committed when it expires.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_left[k] = 0;
        m_hi[k]   = '0;
        m_lo[k]   = '0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_hi[k] = m_phi[k];
          m_lo[k] = m_plo[k];
        end
      end else if (valid[k] && aluop[k] == 2'd2) begin
        if (funct[k] inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
          md_ref(WS[k], funct[k], rs[k], rt[k], m_phi[k], m_plo[k]);
          m_left[k] = WS[k] + 1;
        end else if (funct[k] == 6'h11) m_hi[k] = rs[k] & mask_of(WS[k]);
        else if (funct[k] == 6'h13) m_lo[k] = rs[k] & mask_of(WS[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        logic        exp_busy, exp_stall;
        logic [31:0] exp_hilo;
        exp_busy  = (m_left[k] > 0);
        exp_stall = valid[k] && aluop[k] == 2'd2 && hilo_class(funct[k]) && exp_busy;
        exp_hilo  = '0;
        if (aluop[k] == 2'd2 && funct[k] == 6'h10) exp_hilo = m_hi[k];
        else if (aluop[k] == 2'd2 && funct[k] == 6'h12) exp_hilo = m_lo[k];
        check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(exp_busy));
        check($sformatf("stall[%0d]", k), 32'(stall_o[k]), 32'(exp_stall));
        check($sformatf("aluctl[%0d]", k), 32'(aluctl_o[k]), 32'(ctl_ref(aluop[k], funct[k])));
        check($sformatf("hilo_out[%0d]", k), hilo_o[k], exp_hilo);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    valid[k] = 1'b0;
    aluop[k] = 2'd0;
    funct[k] = 6'h00;
    rs[k]    = '0;
    rt[k]    = '0;
  endtask

  task automatic issue(input int k, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid[k] = 1'b1;
    aluop[k] = 2'd2;
    funct[k] = f;
    rs[k]    = a;
    rt[k]    = b;
    cyc();
    idle(k);
  endtask

  task automatic rand_noise(input int k);
    valid[k] = 1'($urandom);
    aluop[k] = 2'($urandom);
    funct[k] = ($urandom_range(1, 0) == 1) ? 6'($urandom) : 6'(6'h10 + 6'($urandom_range(11, 0)));
    rs[k]    = $urandom;
    rt[k]    = $urandom;
  endtask

  task automatic wait_idle(input int k, input bit noise);
    int n = 0;
    while (busy_o[k] && n < 2 * WS[k] + 8) begin
      if (noise) rand_noise(k);
      cyc();
      idle(k);
      n++;
    end
    check($sformatf("idle_in_budget[%0d]", k), 32'(busy_o[k]), 32'd0);
  endtask

  task automatic read_reg(input int k, input logic [5:0] f, output logic [31:0] v);
    valid[k] = 1'b1;
    aluop[k] = 2'd2;
    funct[k] = f;
    @(negedge clk);
    v = hilo_o[k];
    cyc();
    idle(k);
  endtask

  function automatic logic [31:0] pick_op(input int w);
    logic [31:0] m;
    m = mask_of(w);
    case ($urandom_range(6, 0))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return 32'd1 << (w - 1);
      4: return 32'($urandom_range(9, 2));
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, a, b;
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) idle(k);
    repeat (2) cyc();
    cmp_en = 1'b1;
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    rst_n = 1'b1;
    read_reg(0, 6'h10, v);
    check("reset_hi", v, 32'd0);

    aluop[0] = 2'd2; funct[0] = 6'h2B;
    @(negedge clk); check("aluctl_sltu", 32'(aluctl_o[0]), 32'd8);
    cyc(); aluop[0] = 2'd1; funct[0] = 6'h2A;
    @(negedge clk); check("aluctl_beq", 32'(aluctl_o[0]), 32'd6);
    cyc(); aluop[0] = 2'd2; funct[0] = 6'h3F;
    @(negedge clk); check("aluctl_unknown", 32'(aluctl_o[0]), 32'd0);
    cyc(); idle(0);

    issue(0, 6'h18, 32'hFFFF_FFFF, 32'h0000_0003);
    n = 0;
    while (busy_o[0] && n < 100) begin n++; cyc(); end
    check("mult_busy_cycles", 32'(n), 32'd33);
    read_reg(0, 6'h10, v); check("mult_hi", v, 32'hFFFF_FFFF);
    read_reg(0, 6'h12, v); check("mult_lo", v, 32'hFFFF_FFFD);

    issue(0, 6'h1A, 32'hFFFF_FFF9, 32'd2);
    wait_idle(0, 1'b0);
    read_reg(0, 6'h12, v); check("div_lo", v, 32'hFFFF_FFFD);
    read_reg(0, 6'h10, v); check("div_hi", v, 32'hFFFF_FFFF);
    issue(0, 6'h1B, 32'd7, 32'd0);
    wait_idle(0, 1'b0);
    read_reg(0, 6'h12, v); check("divu0_lo", v, 32'hFFFF_FFFF);
    read_reg(0, 6'h10, v); check("divu0_hi", v, 32'd7);

    issue(0, 6'h19, 32'h0001_2345, 32'h0000_1000);
    valid[0] = 1'b1; aluop[0] = 2'd2; funct[0] = 6'h12;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!stall_o[0]) break;
      n++;
      cyc();
    end
    check("mflo_stall_cycles", 32'(n), 32'd33);
    check("mflo_after_stall", hilo_o[0], 32'h1234_5000);
    cyc(); idle(0);

    issue(0, 6'h18, 32'd5, 32'd6);
    valid[0] = 1'b1; aluop[0] = 2'd2; funct[0] = 6'h20;
    @(negedge clk);
    check("add_busy_no_stall", 32'(stall_o[0]), 32'd0);
    check("add_busy_flag", 32'(busy_o[0]), 32'd1);
    cyc(); idle(0);
    wait_idle(0, 1'b0);

    issue(0, 6'h1A, 32'd100, 32'd7);
    repeat (9) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("rst_mid_div_busy", 32'(busy_o[0]), 32'd0);
    read_reg(0, 6'h10, v); check("rst_mid_div_hi", v, 32'd0);
    read_reg(0, 6'h12, v); check("rst_mid_div_lo", v, 32'd0);
    issue(0, 6'h19, 32'd2, 32'd3);
    wait_idle(0, 1'b0);
    read_reg(0, 6'h12, v); check("multu_2x3_lo", v, 32'd6);

    issue(0, 6'h11, 32'hDEAD_BEEF, 32'd0);
    read_reg(0, 6'h10, v); check("mthi", v, 32'hDEAD_BEEF);
    valid[0] = 1'b0; aluop[0] = 2'd2; funct[0] = 6'h13; rs[0] = 32'h5555_5555;
    cyc(); idle(0);
    read_reg(0, 6'h12, v); check("mtlo_invalid_ignored", v, 32'd6);

    for (int k = 0; k < NI; k++) begin
      int nops;
      nops = (k == 0) ? 100 : 1000;
      for (int i = 0; i < nops; i++) begin
        if ($urandom_range(9, 0) == 0) begin
          issue(k, ($urandom_range(1, 0) == 1) ? 6'h11 : 6'h13, $urandom, $urandom);
        end else begin
          a = pick_op(WS[k]);
          b = ($urandom_range(15, 0) == 0) ? 32'd0 : pick_op(WS[k]);
          issue(k, 6'(6'h18 + 6'($urandom_range(3, 0))), a, b);
          wait_idle(k, 1'b1);
        end
        read_reg(k, 6'h10, v);
        read_reg(k, 6'h12, v);
      end
    end

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
